// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// The baud divisor and the byte are captured at acceptance and held for the whole frame.
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int CNT_W      = 16
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic [2:0] buad_set_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       uart_tx_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Rounded bit period in clocks: (CLK_FREQ + baud/2) / baud.
    function automatic logic [CNT_W-1:0] baud_div(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0:    baud = 9600;
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            3'd4:    baud = 115200;
            3'd5:    baud = 230400;
            3'd6:    baud = 460800;
            default: baud = 921600;
        endcase
        return CNT_W'((CLK_FREQ + baud / 2) / baud);
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic             tx_q, tx_nxt;
    logic             done_q, done_nxt;
    logic             accept, shift, bit_end;
    logic [7:0]       shreg;
    logic [CNT_W-1:0] div_q;
    logic             par_q;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            tx_q    <= tx_nxt;
            done_q  <= done_nxt;
        end
    end

    // Frame payload and divisor: loaded only on acceptance, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            shreg <= tx_data_i;
            div_q <= baud_div(buad_set_i);
            par_q <= ^tx_data_i ^ (PARITY_ODD != 0);
        end else if (shift) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        tx_nxt    = tx_q;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        shift     = 1'b0;
        bit_end   = (cnt == div_q - CNT_W'(1));
        if (state == IDLE) begin
            tx_nxt = 1'b1;
            if (tx_valid_i) begin
                accept    = 1'b1;
                state_nxt = START;
                cnt_nxt   = '0;
                bit_nxt   = '0;
                tx_nxt    = 1'b0;
            end
        end else begin
            cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
            if (bit_end) begin
                case (state)
                    START: begin
                        state_nxt = DATA;
                        tx_nxt    = shreg[0];
                        shift     = 1'b1;
                    end
                    DATA: begin
                        if (bit_cnt != 3'd7) begin
                            bit_nxt = bit_cnt + 3'd1;
                            tx_nxt  = shreg[0];
                            shift   = 1'b1;
                        end else if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_q;
                        end else begin
                            state_nxt = STOP;
                            bit_nxt   = '0;
                            tx_nxt    = 1'b1;
                        end
                    end
                    PARITY: begin
                        state_nxt = STOP;
                        bit_nxt   = '0;
                        tx_nxt    = 1'b1;
                    end
                    STOP: begin
                        tx_nxt = 1'b1;
                        if (bit_cnt == 3'(STOP_BITS - 1)) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    assign tx_ready_o = (state == IDLE);
    assign tx_busy_o  = (state != IDLE);
    assign tx_done_o  = done_q;
    assign uart_tx_o  = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no-parity/1-stop, even and odd
// parity, and two stop bits, all at CLK_FREQ = 100 MHz.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] buad = 3'd5;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] vld = 4'b0000;
    logic [3:0] rdy, busy, done_v, line;
    int         checks = 0;
    int         errors = 0;
    int         ndone = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (done_v[0]) ndone <= ndone + 1;

    uart_tx dut0 (
        .clk_i(clk), .rst(rst), .buad_set_i(buad), .tx_data_i(tx_data), .tx_valid_i(vld[0]),
        .tx_ready_o(rdy[0]), .tx_busy_o(busy[0]), .tx_done_o(done_v[0]), .uart_tx_o(line[0])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk_i(clk), .rst(rst), .buad_set_i(buad), .tx_data_i(tx_data), .tx_valid_i(vld[1]),
        .tx_ready_o(rdy[1]), .tx_busy_o(busy[1]), .tx_done_o(done_v[1]), .uart_tx_o(line[1])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk_i(clk), .rst(rst), .buad_set_i(buad), .tx_data_i(tx_data), .tx_valid_i(vld[2]),
        .tx_ready_o(rdy[2]), .tx_busy_o(busy[2]), .tx_done_o(done_v[2]), .uart_tx_o(line[2])
    );
    uart_tx #(.STOP_BITS(2)) dut_stop2 (
        .clk_i(clk), .rst(rst), .buad_set_i(buad), .tx_data_i(tx_data), .tx_valid_i(vld[3]),
        .tx_ready_o(rdy[3]), .tx_busy_o(busy[3]), .tx_done_o(done_v[3]), .uart_tx_o(line[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line levels: bit0 start, bits 8:1 data, optional parity at 9, rest idle/stop high.
    function automatic logic [11:0] fb(input logic [7:0] d, input bit pe, input bit p);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (pe) f[9] = p;
        return f;
    endfunction

    // Called 1 ns after an edge with the DUT idle; returns 1 ns after the acceptance edge.
    task automatic start(input int i, input logic [7:0] d);
        tx_data = d;
        vld[i]  = 1'b1;
        @(posedge clk); #1;
        vld[i]  = 1'b0;
        check("start_low", line[i], 1'b0);
        check("ready_low", rdy[i], 1'b0);
        check("busy_high", busy[i], 1'b1);
    endtask

    // Checks the first and last cycle of every bit, then the done cycle.
    task automatic frame(input int i, input logic [11:0] bits, input int n, input int div);
        for (int b = 0; b < n; b++) begin
            check($sformatf("bit%0d_first", b), line[i], bits[b]);
            repeat (div - 1) @(posedge clk);
            #1;
            check($sformatf("bit%0d_last", b), line[i], bits[b]);
            check($sformatf("bit%0d_nodone", b), done_v[i], 1'b0);
            @(posedge clk); #1;
        end
        check("done_pulse", done_v[i], 1'b1);
        check("ready_end", rdy[i], 1'b1);
        check("busy_end", busy[i], 1'b0);
        check("line_idle", line[i], 1'b1);
    endtask

    task automatic done_clear(input int i);
        @(posedge clk); #1;
        check("done_clear", done_v[i], 1'b0);
    endtask

    initial begin
        int n0;
        int lows;

        repeat (3) @(posedge clk);
        #1;
        check("rst_line", line[0], 1'b1);
        check("rst_ready", rdy[0], 1'b1);
        check("rst_busy", busy[0], 1'b0);
        check("rst_done", done_v[0], 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 0x55 at sel5: DIV = 434, done 4340 cycles after acceptance
        start(0, 8'h55);
        frame(0, fb(8'h55, 0, 0), 10, 434);
        done_clear(0);

        // 0xA5 at several rates: sel5 434, sel4 868, sel7 109
        start(0, 8'hA5);
        frame(0, fb(8'hA5, 0, 0), 10, 434);
        done_clear(0);
        buad = 3'd4;
        start(0, 8'hA5);
        frame(0, fb(8'hA5, 0, 0), 10, 868);
        done_clear(0);
        buad = 3'd7;
        start(0, 8'hA5);
        frame(0, fb(8'hA5, 0, 0), 10, 109);
        done_clear(0);
        buad = 3'd5;

        // Back-to-back with valid held high
        n0 = ndone;
        tx_data = 8'h11;
        vld[0]  = 1'b1;
        @(posedge clk); #1;
        check("b2b_start1", line[0], 1'b0);
        tx_data = 8'h22;
        frame(0, fb(8'h11, 0, 0), 10, 434);
        @(posedge clk); #1;
        check("b2b_start2", line[0], 1'b0);
        tx_data = 8'h33;
        frame(0, fb(8'h22, 0, 0), 10, 434);
        @(posedge clk); #1;
        check("b2b_start3", line[0], 1'b0);
        vld[0] = 1'b0;
        frame(0, fb(8'h33, 0, 0), 10, 434);
        done_clear(0);
        check("b2b_done_count", ndone - n0, 3);

        // Mid-frame valid pulse and baud change must not disturb the frame
        start(0, 8'h00);
        fork
            frame(0, fb(8'h00, 0, 0), 10, 434);
            begin
                repeat (1500) @(posedge clk);
                #2;
                tx_data = 8'hFF;
                vld[0]  = 1'b1;
                buad    = 3'd4;
                @(posedge clk); #2;
                vld[0]  = 1'b0;
            end
        join
        done_clear(0);
        lows = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (!line[0]) lows++;
        end
        check("ff_not_sent", lows, 0);
        check("ff_idle_ready", rdy[0], 1'b1);
        buad = 3'd5;

        // Reset during data bit 3 of 0xF0 (line low there)
        start(0, 8'hF0);
        repeat (4 * 434 + 200) @(posedge clk);
        #1;
        check("pre_rst_bit3", line[0], 1'b0);
        n0 = ndone;
        #2 rst = 1'b1;
        #1;
        check("rst_async_line", line[0], 1'b1);
        check("rst_async_ready", rdy[0], 1'b1);
        check("rst_async_busy", busy[0], 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_done", ndone - n0, 0);
        check("rst_idle_line", line[0], 1'b1);
        start(0, 8'h3C);
        frame(0, fb(8'h3C, 0, 0), 10, 434);
        done_clear(0);

        // Parity: 0x07 has three ones -> even parity bit 1, odd parity bit 0
        start(1, 8'h07);
        frame(1, fb(8'h07, 1, 1'b1), 11, 434);
        done_clear(1);
        start(2, 8'h07);
        frame(2, fb(8'h07, 1, 1'b0), 11, 434);
        done_clear(2);

        // Two stop bits: line high 868 cycles before done
        start(3, 8'h00);
        frame(3, fb(8'h00, 0, 0), 11, 434);
        done_clear(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
